// File: rtl/calc_pkg.sv
// calc_pkg: shared command/response encodings, port FSM states and ALU request/result types
package calc_pkg;
  localparam int DATA_W = 32;
  typedef enum logic [3:0] {
    CMD_NONE = 4'd0,
    CMD_ADD  = 4'd1,
    CMD_SUB  = 4'd2,
    CMD_SHL  = 4'd5,
    CMD_SHR  = 4'd6
  } cmd_e;
  typedef enum logic [1:0] {
    RESP_NONE = 2'd0,
    RESP_OK   = 2'd1,
    RESP_ERR  = 2'd2
  } resp_e;
  typedef enum logic [2:0] {ST_IDLE, ST_OP2, ST_PEND, ST_WAIT, ST_RESP} port_st_e;
  typedef struct packed {
    logic              valid;
    logic [1:0]        id;
    logic [3:0]        cmd;
    logic [DATA_W-1:0] op1;
    logic [DATA_W-1:0] op2;
  } alu_req_t;
  typedef struct packed {
    logic              valid;
    logic [1:0]        id;
    resp_e             resp;
    logic [DATA_W-1:0] data;
  } alu_res_t;
  function automatic logic cmd_ok(logic [3:0] c);
    return c inside {CMD_ADD, CMD_SUB, CMD_SHL, CMD_SHR};
  endfunction
endpackage

// File: rtl/calc_alu.sv
// calc_alu: shared ALU_LAT-deep arithmetic pipeline; carries the port id tag with each result
//   c_clk, reset_n : clock, async active-low reset (clears the pipeline)
//   req_i          : issued request {valid, id, cmd, op1, op2}
//   res_o          : result {valid, id, resp, data}, ALU_LAT cycles after issue
module calc_alu
  import calc_pkg::*;
#(
  parameter int ALU_LAT = 2
) (
  input  logic     c_clk,
  input  logic     reset_n,
  input  alu_req_t req_i,
  output alu_res_t res_o
);
  logic [DATA_W:0]   sum;
  logic [DATA_W-1:0] val;
  logic              err;
  alu_res_t          res_d;
  alu_res_t          pipe_q [ALU_LAT];
  assign sum = {1'b0, req_i.op1} + {1'b0, req_i.op2};
  assign val = (req_i.cmd == CMD_ADD) ? sum[DATA_W-1:0] :
               (req_i.cmd == CMD_SUB) ? req_i.op1 - req_i.op2 :
               (req_i.cmd == CMD_SHL) ? req_i.op1 << req_i.op2[4:0] :
                                        req_i.op1 >> req_i.op2[4:0];
  assign err = (req_i.cmd == CMD_ADD) ? sum[DATA_W] :
               (req_i.cmd == CMD_SUB) ? (req_i.op2 > req_i.op1) :
               !(req_i.cmd == CMD_SHL || req_i.cmd == CMD_SHR);
  assign res_d = '{valid: req_i.valid, id: req_i.id, resp: err ? RESP_ERR : RESP_OK,
                   data: err ? {DATA_W{1'b0}} : val};
  always_ff @(posedge c_clk or negedge reset_n)
    if (!reset_n) begin
      for (int i = 0; i < ALU_LAT; i++) pipe_q[i] <= '0;
    end else begin
      pipe_q[0] <= res_d;
      for (int i = 1; i < ALU_LAT; i++) pipe_q[i] <= pipe_q[i-1];
    end
  assign res_o = pipe_q[ALU_LAT-1];
endmodule

// File: rtl/calc_port_scheduler.sv
// calc_port_scheduler: four calculator ports sharing one pipelined ALU through a one-grant-per-cycle arbiter
//   c_clk, reset_n           : clock, async active-low reset
//   reqN_cmd_in/reqN_data_in : per-port command, then op1 (command cycle) and op2 (next cycle)
//   out_respN/out_dataN      : one-cycle response (1 ok, 2 error) and result (0 unless ok)
//   CALC_SCHED_RR_EN         : defined -> round-robin arbitration, else fixed priority (port 1 highest)
module calc_port_scheduler
  import calc_pkg::*;
#(
  parameter int ALU_LAT = 2
) (
  input  logic              c_clk,
  input  logic              reset_n,
  input  logic [3:0]        req1_cmd_in,
  input  logic [3:0]        req2_cmd_in,
  input  logic [3:0]        req3_cmd_in,
  input  logic [3:0]        req4_cmd_in,
  input  logic [DATA_W-1:0] req1_data_in,
  input  logic [DATA_W-1:0] req2_data_in,
  input  logic [DATA_W-1:0] req3_data_in,
  input  logic [DATA_W-1:0] req4_data_in,
  output logic [1:0]        out_resp1,
  output logic [1:0]        out_resp2,
  output logic [1:0]        out_resp3,
  output logic [1:0]        out_resp4,
  output logic [DATA_W-1:0] out_data1,
  output logic [DATA_W-1:0] out_data2,
  output logic [DATA_W-1:0] out_data3,
  output logic [DATA_W-1:0] out_data4
);
  logic [3:0]        cmd_in   [4];
  logic [DATA_W-1:0] data_in  [4];
  logic [1:0]        resp_out [4];
  logic [DATA_W-1:0] data_out [4];
  alu_req_t          port_req [4];
  alu_req_t          issue;
  alu_res_t          res;
  logic              gnt_v;
  logic [1:0]        gnt_id;
  logic [1:0]        base;
  assign cmd_in  = '{req1_cmd_in, req2_cmd_in, req3_cmd_in, req4_cmd_in};
  assign data_in = '{req1_data_in, req2_data_in, req3_data_in, req4_data_in};
  assign out_resp1 = resp_out[0];
  assign out_resp2 = resp_out[1];
  assign out_resp3 = resp_out[2];
  assign out_resp4 = resp_out[3];
  assign out_data1 = data_out[0];
  assign out_data2 = data_out[1];
  assign out_data3 = data_out[2];
  assign out_data4 = data_out[3];
`ifdef CALC_SCHED_RR_EN
  logic [1:0] ptr_q, ptr_d;
  assign ptr_d = gnt_v ? gnt_id + 2'd1 : ptr_q;
  always_ff @(posedge c_clk or negedge reset_n)
    if (!reset_n) ptr_q <= 2'd0;
    else ptr_q <= ptr_d;
  assign base = ptr_q;
`else
  assign base = 2'd0;
`endif
  // Scan downward so the pending port closest to base is the one left standing.
  always_comb begin
    gnt_v  = 1'b0;
    gnt_id = base;
    for (int i = 3; i >= 0; i--)
      if (port_req[2'(base + 2'(i))].valid) begin
        gnt_v  = 1'b1;
        gnt_id = 2'(base + 2'(i));
      end
  end
  // With no grant, gnt_id points at a non-pending port, so its valid bit is already 0.
  assign issue = port_req[gnt_id];
  calc_alu #(.ALU_LAT(ALU_LAT)) u_alu (
    .c_clk  (c_clk),
    .reset_n(reset_n),
    .req_i  (issue),
    .res_o  (res)
  );
  for (genvar p = 0; p < 4; p++) begin : g_port
    port_st_e          st_q, st_d;
    logic [3:0]        cmd_q, cmd_d;
    logic [DATA_W-1:0] op1_q, op1_d, op2_q, op2_d, data_q, data_d;
    resp_e             resp_q, resp_d;
    always_ff @(posedge c_clk or negedge reset_n)
      if (!reset_n) begin
        st_q   <= ST_IDLE;
        cmd_q  <= '0;
        op1_q  <= '0;
        op2_q  <= '0;
        data_q <= '0;
        resp_q <= RESP_NONE;
      end else begin
        st_q   <= st_d;
        cmd_q  <= cmd_d;
        op1_q  <= op1_d;
        op2_q  <= op2_d;
        data_q <= data_d;
        resp_q <= resp_d;
      end
    always_comb begin
      st_d   = st_q;
      cmd_d  = cmd_q;
      op1_d  = op1_q;
      op2_d  = op2_q;
      data_d = data_q;
      resp_d = resp_q;
      case (st_q)
        ST_IDLE: if (cmd_in[p] != 4'd0) begin
          st_d  = ST_OP2;
          cmd_d = cmd_in[p];
          op1_d = data_in[p];
        end
        ST_OP2: begin
          op2_d  = data_in[p];
          st_d   = cmd_ok(cmd_q) ? ST_PEND : ST_RESP;
          resp_d = RESP_ERR;
          data_d = '0;
        end
        ST_PEND: if (gnt_v && gnt_id == 2'(p)) st_d = ST_WAIT;
        ST_WAIT: if (res.valid && res.id == 2'(p)) begin
          st_d   = ST_RESP;
          resp_d = res.resp;
          data_d = res.data;
        end
        default: st_d = ST_IDLE;
      endcase
    end
    assign port_req[p] = '{valid: st_q == ST_PEND, id: 2'(p), cmd: cmd_q, op1: op1_q, op2: op2_q};
    assign resp_out[p] = (st_q == ST_RESP) ? resp_q : RESP_NONE;
    assign data_out[p] = (st_q == ST_RESP) ? data_q : '0;
  end
endmodule

// File: tb/tb_calc_port_scheduler.sv
// tb_calc_port_scheduler: directed self-checking bench for calc_port_scheduler
module tb_calc_port_scheduler;
  logic        c_clk = 1'b0;
  logic        reset_n = 1'b1;
  logic [3:0]  cmd  [4];
  logic [31:0] din  [4];
  logic [1:0]  resp [4];
  logic [31:0] dout [4];
  int n_chk = 0;
  int n_pass = 0;

  always #5 c_clk = ~c_clk;

  calc_port_scheduler #(.ALU_LAT(2)) dut (
    .c_clk(c_clk), .reset_n(reset_n),
    .req1_cmd_in(cmd[0]), .req2_cmd_in(cmd[1]), .req3_cmd_in(cmd[2]), .req4_cmd_in(cmd[3]),
    .req1_data_in(din[0]), .req2_data_in(din[1]), .req3_data_in(din[2]), .req4_data_in(din[3]),
    .out_resp1(resp[0]), .out_resp2(resp[1]), .out_resp3(resp[2]), .out_resp4(resp[3]),
    .out_data1(dout[0]), .out_data2(dout[1]), .out_data3(dout[2]), .out_data4(dout[3])
  );

  task automatic tick();
    @(posedge c_clk);
    #1;
  endtask

  task automatic idle_all();
    for (int p = 0; p < 4; p++) begin
      cmd[p] = 4'd0;
      din[p] = 32'd0;
    end
  endtask

  task automatic do_reset();
    idle_all();
    reset_n = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
  endtask

  // Drives command cycle T and operand cycle T+1; returns at the start of T+2.
  task automatic send(input int p, input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
    cmd[p] = c;
    din[p] = a;
    tick();
    cmd[p] = 4'd0;
    din[p] = b;
    tick();
    din[p] = 32'd0;
  endtask

  task automatic test_reset();
    idle_all();
    cmd[0] = 4'd1;
    din[0] = 32'h5;
    #3 reset_n = 1'b0;
    #1;
    for (int p = 0; p < 4; p++) begin
      n_chk++;
      if (resp[p] !== 2'd0 || dout[p] !== 32'd0)
        $display("FAIL reset_p%0d: resp=%0d data=%h, expected resp=0 data=0", p + 1, resp[p], dout[p]);
      else n_pass++;
    end
    do_reset();
  endtask

  task automatic test_add();
    do_reset();
    send(0, 4'd1, 32'h5, 32'h7);
    for (int k = 2; k <= 7; k++) begin
      n_chk++;
      if (resp[0] !== (k == 5 ? 2'd1 : 2'd0) || dout[0] !== (k == 5 ? 32'hC : 32'h0))
        $display("FAIL add_p1_t%0d: resp=%0d data=%h, expected resp=%0d data=%h",
                 k, resp[0], dout[0], k == 5, k == 5 ? 32'hC : 32'h0);
      else n_pass++;
      n_chk++;
      if ({resp[1], resp[2], resp[3]} !== 6'd0)
        $display("FAIL add_others_t%0d: resp2..4=%b, expected 000000", k, {resp[1], resp[2], resp[3]});
      else n_pass++;
      tick();
    end
  endtask

  task automatic test_overflow();
    logic [3:0]  c [3];
    logic [31:0] a [3];
    logic [31:0] b [3];
    logic [1:0]  er [3];
    logic [31:0] ed [3];
    c  = '{4'd1, 4'd2, 4'd2};
    a  = '{32'hFFFF_FFFF, 32'h3, 32'h9};
    b  = '{32'h1, 32'h4, 32'h4};
    er = '{2'd2, 2'd2, 2'd1};
    ed = '{32'h0, 32'h0, 32'h5};
    do_reset();
    for (int v = 0; v < 3; v++) begin
      send(1, c[v], a[v], b[v]);
      tick();
      tick();
      n_chk++;
      if (resp[1] !== 2'd0)
        $display("FAIL ovf%0d_early: resp=%0d, expected 0 at T+4", v, resp[1]);
      else n_pass++;
      tick();
      n_chk++;
      if (resp[1] !== er[v] || dout[1] !== ed[v])
        $display("FAIL ovf%0d_resp: resp=%0d data=%h, expected resp=%0d data=%h", v, resp[1], dout[1], er[v], ed[v]);
      else n_pass++;
      tick();
    end
  endtask

  task automatic test_shift();
    logic [3:0]  c [2];
    logic [31:0] a [2];
    logic [31:0] b [2];
    logic [31:0] ed [2];
    c  = '{4'd5, 4'd6};
    a  = '{32'h1, 32'h8000_0000};
    b  = '{32'h24, 32'd31};
    ed = '{32'h10, 32'h1};
    do_reset();
    for (int v = 0; v < 2; v++) begin
      send(2, c[v], a[v], b[v]);
      tick();
      tick();
      tick();
      n_chk++;
      if (resp[2] !== 2'd1 || dout[2] !== ed[v])
        $display("FAIL shift%0d: resp=%0d data=%h, expected resp=1 data=%h", v, resp[2], dout[2], ed[v]);
      else n_pass++;
      tick();
    end
  endtask

  task automatic test_invalid();
    do_reset();
    cmd[3] = 4'd3;
    din[3] = 32'h1234;
    tick();
    cmd[3] = 4'd0;
    din[3] = 32'h5678;
    for (int k = 1; k <= 5; k++) begin
      n_chk++;
      if (dut.issue.valid !== 1'b0 || dut.res.valid !== 1'b0)
        $display("FAIL invalid_alu_t%0d: issue_valid=%b res_valid=%b, expected 0/0", k, dut.issue.valid, dut.res.valid);
      else n_pass++;
      if (k == 2) begin
        n_chk++;
        if (resp[3] !== 2'd2 || dout[3] !== 32'd0)
          $display("FAIL invalid_resp: resp=%0d data=%h, expected resp=2 data=0", resp[3], dout[3]);
        else n_pass++;
      end
      if (k == 3) begin
        n_chk++;
        if (resp[3] !== 2'd0)
          $display("FAIL invalid_oneshot: resp=%0d, expected 0 at T+3", resp[3]);
        else n_pass++;
      end
      tick();
      din[3] = 32'd0;
    end
  endtask

  task automatic test_busy_ignore();
    do_reset();
    send(0, 4'd1, 32'h5, 32'h7);
    cmd[0] = 4'd2;
    din[0] = 32'd99;
    tick();
    tick();
    cmd[0] = 4'd0;
    din[0] = 32'd0;
    tick();
    n_chk++;
    if (resp[0] !== 2'd1 || dout[0] !== 32'hC)
      $display("FAIL busy_resp: resp=%0d data=%h, expected resp=1 data=c", resp[0], dout[0]);
    else n_pass++;
    for (int k = 6; k <= 9; k++) begin
      tick();
      n_chk++;
      if (resp[0] !== 2'd0)
        $display("FAIL busy_extra_t%0d: resp=%0d, expected 0", k, resp[0]);
      else n_pass++;
    end
  endtask

  task automatic test_all_four();
    do_reset();
    for (int p = 0; p < 4; p++) begin
      cmd[p] = 4'd1;
      din[p] = 32'(p + 1);
    end
    tick();
    for (int p = 0; p < 4; p++) cmd[p] = 4'd0;
    tick();
    idle_all();
    for (int k = 2; k <= 9; k++) begin
      for (int p = 0; p < 4; p++) begin
        n_chk++;
        if (resp[p] !== (k == 5 + p ? 2'd1 : 2'd0) || dout[p] !== (k == 5 + p ? 32'(2 * (p + 1)) : 32'd0))
          $display("FAIL all4_p%0d_t%0d: resp=%0d data=%h, expected resp=%0d data=%h",
                   p + 1, k, resp[p], dout[p], k == 5 + p, k == 5 + p ? 2 * (p + 1) : 0);
        else n_pass++;
      end
      tick();
    end
  endtask

  task automatic test_back_to_back();
    int slot;
    do_reset();
    send(0, 4'd1, 32'h1, 32'h1);
    tick();
    tick();
    tick();
    n_chk++;
    if (resp[0] !== 2'd1 || dout[0] !== 32'h2)
      $display("FAIL b2b_first: resp=%0d data=%h, expected resp=1 data=2", resp[0], dout[0]);
    else n_pass++;
    tick();
    for (int p = 0; p < 4; p++) begin
      cmd[p] = 4'd1;
      din[p] = 32'(10 + p);
    end
    tick();
    for (int p = 0; p < 4; p++) begin
      cmd[p] = 4'd0;
      din[p] = 32'(p);
    end
    tick();
    idle_all();
    for (int k = 2; k <= 9; k++) begin
      for (int p = 0; p < 4; p++) begin
`ifdef CALC_SCHED_RR_EN
        slot = (p + 3) % 4;
`else
        slot = p;
`endif
        n_chk++;
        if (resp[p] !== (k == 5 + slot ? 2'd1 : 2'd0) || dout[p] !== (k == 5 + slot ? 32'(10 + 2 * p) : 32'd0))
          $display("FAIL b2b_p%0d_t%0d: resp=%0d data=%h, expected resp=%0d data=%h",
                   p + 1, k, resp[p], dout[p], k == 5 + slot, k == 5 + slot ? 10 + 2 * p : 0);
        else n_pass++;
      end
      tick();
    end
  endtask

  task automatic test_reset_inflight();
    do_reset();
    send(0, 4'd1, 32'h5, 32'h7);
    tick();
    reset_n = 1'b0;
    #1;
    n_chk++;
    if ({resp[0], resp[1], resp[2], resp[3]} !== 8'd0 || {dout[0], dout[1], dout[2], dout[3]} !== 128'd0)
      $display("FAIL rst_mid_outputs: resp=%b data1=%h, expected all 0", {resp[0], resp[1], resp[2], resp[3]}, dout[0]);
    else n_pass++;
    tick();
    reset_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      tick();
      n_chk++;
      if (resp[0] !== 2'd0)
        $display("FAIL rst_ghost_c%0d: resp=%0d, expected 0", k, resp[0]);
      else n_pass++;
    end
    send(0, 4'd1, 32'h5, 32'h7);
    tick();
    tick();
    tick();
    n_chk++;
    if (resp[0] !== 2'd1 || dout[0] !== 32'hC)
      $display("FAIL rst_after_add: resp=%0d data=%h, expected resp=1 data=c", resp[0], dout[0]);
    else n_pass++;
    #2 reset_n = 1'b0;
    #1;
    n_chk++;
    if (resp[0] !== 2'd0 || dout[0] !== 32'd0)
      $display("FAIL rst_async_clear: resp=%0d data=%h, expected resp=0 data=0", resp[0], dout[0]);
    else n_pass++;
    tick();
    reset_n = 1'b1;
  endtask

  initial begin
    idle_all();
    test_reset();
    test_add();
    test_overflow();
    test_shift();
    test_invalid();
    test_busy_ignore();
    test_all_four();
    test_back_to_back();
    test_reset_inflight();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end
endmodule
